// File: rtl/weight_seq_ctrl.sv
// Weight buffer read sequencer: walks col-fastest, then row, then filter, with back-pressure.
// Optional build macro WEIGHT_SEQ_ABORT_EN adds an abort input that cancels a pass.
module weight_seq_ctrl #(
    parameter int WEIGHT_SIZE_COL = 7,
    parameter int WEIGHT_SIZE_ROW = 28,
    parameter int WEIGHT_ADDR_COL = 3,
    parameter int WEIGHT_ADDR_ROW = 5,
    parameter int NUM_FILTER      = 4,
    parameter int FILTER_ADDR     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       conv_ready,
`ifdef WEIGHT_SEQ_ABORT_EN
    input  logic                       abort,
`endif
    output logic                       weight_read_en,
    output logic [WEIGHT_ADDR_COL-1:0] weight_addr_col,
    output logic [WEIGHT_ADDR_ROW-1:0] weight_addr_row,
    output logic [FILTER_ADDR-1:0]     filter_idx,
    output logic                       weight_last,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    localparam logic [WEIGHT_ADDR_COL-1:0] COL_LAST = WEIGHT_ADDR_COL'(WEIGHT_SIZE_COL - 1);
    localparam logic [WEIGHT_ADDR_ROW-1:0] ROW_LAST = WEIGHT_ADDR_ROW'(WEIGHT_SIZE_ROW - 1);
    localparam logic [FILTER_ADDR-1:0]     FLT_LAST = FILTER_ADDR'(NUM_FILTER - 1);

    state_t                     state_q, state_d;
    logic [WEIGHT_ADDR_COL-1:0] col_q, col_d;
    logic [WEIGHT_ADDR_ROW-1:0] row_q, row_d;
    logic [FILTER_ADDR-1:0]     flt_q, flt_d;
    logic                       abort_w;
    logic                       col_end, row_end, flt_end, beat;

`ifdef WEIGHT_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // Explicit terminal compares so non-power-of-two sizes wrap correctly.
    assign col_end = (col_q == COL_LAST);
    assign row_end = (row_q == ROW_LAST);
    assign flt_end = (flt_q == FLT_LAST);
    assign beat    = (state_q == READ) && conv_ready && !abort_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            flt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        flt_d   = flt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                    col_d   = '0;
                    row_d   = '0;
                    flt_d   = '0;
                end
            end
            READ: begin
                if (beat) begin
                    if (col_end) begin
                        col_d = '0;
                        if (row_end) begin
                            row_d = '0;
                            if (flt_end) begin
                                flt_d   = '0;
                                state_d = DONE;
                            end else begin
                                flt_d = flt_q + 1'b1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks both start and beat acceptance, but only once a pass is running.
        if (abort_w && (state_q != IDLE)) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            flt_d   = '0;
        end
    end

    assign weight_read_en  = beat;
    assign weight_addr_col = col_q;
    assign weight_addr_row = row_q;
    assign filter_idx      = flt_q;
    assign weight_last     = (state_q == READ) && row_end && col_end;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// Directed bench for weight_seq_ctrl: reset, full pass, back-pressure, ignored starts, mid-pass reset, abort.
module tb_weight_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, conv_ready;
`ifdef WEIGHT_SEQ_ABORT_EN
    logic       abort;
`endif
    logic       weight_read_en, weight_last, busy, done;
    logic [2:0] weight_addr_col;
    logic [4:0] weight_addr_row;
    logic [1:0] filter_idx;
    logic [9:0] addr;

    int checks = 0;
    int errors = 0;

    assign addr = {filter_idx, weight_addr_row, weight_addr_col};

    always #5 clk = ~clk;

    weight_seq_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .conv_ready      (conv_ready),
`ifdef WEIGHT_SEQ_ABORT_EN
        .abort           (abort),
`endif
        .weight_read_en  (weight_read_en),
        .weight_addr_col (weight_addr_col),
        .weight_addr_row (weight_addr_row),
        .filter_idx      (filter_idx),
        .weight_last     (weight_last),
        .busy            (busy),
        .done            (done)
    );

    function automatic logic [9:0] beat_addr(input int b);
        return {2'(b / 196), 5'((b % 196) / 7), 3'(b % 7)};
    endfunction

    // Drives one pass from IDLE (entered and left at posedge+1) and gathers what it saw.
    task automatic run_pass(input int stall_beat, input int stall_len, input int extra_start_beat,
                            input int stop_beat, input bit start_on_done,
                            output int beats, output int dones, output int order_err,
                            output int last_err, output int stall_good, output logic [9:0] post_addr,
                            output int done_gap, output logic busy_on_done, output logic busy_after);
        int stalled, last_cyc, done_cyc;
        beats = 0; dones = 0; order_err = 0; last_err = 0; stall_good = 0;
        post_addr = '1; done_gap = -1; busy_on_done = 1'b0; busy_after = 1'b1;
        stalled = 0; last_cyc = -1; done_cyc = -1;
        conv_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (stop_beat >= 0 && beats == stop_beat) return;
            start      = (extra_start_beat >= 0 && beats == extra_start_beat) || (start_on_done && done);
            conv_ready = !(beats == stall_beat && stalled < stall_len);
            #1;
            if (!conv_ready) begin
                stalled++;
                if (!weight_read_en && addr == beat_addr(beats) && weight_last) stall_good++;
            end
            if (weight_read_en) begin
                if (addr !== beat_addr(beats)) order_err++;
                if (weight_last !== ((beats % 196) == 195)) last_err++;
                if (stalled > 0 && beats == stall_beat + 1) post_addr = addr;
                beats++;
                last_cyc = cyc;
            end
            if (done) begin
                dones++;
                done_cyc     = cyc;
                busy_on_done = busy;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = busy;
                start = 1'b0;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (done_cyc >= 0) done_gap = done_cyc - last_cyc;
    endtask

    task automatic test_reset();
        int b, d, oe, le, sg, dg;
        logic [9:0] pa;
        logic bd, ba;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || weight_read_en !== 1'b0 || addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold busy=%b done=%b en=%b addr=%h want 0", busy, done, weight_read_en, addr);
        end
        run_pass(-1, 0, -1, 10, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        #2;
        checks++;
        if (weight_read_en !== 1'b1 || addr !== beat_addr(10)) begin
            errors++;
            $display("FAIL pre_reset_beat en=%b addr=%h want 1/%h", weight_read_en, addr, beat_addr(10));
        end
        reset = 1'b1;
        #1;
        checks++;
        if (weight_read_en !== 1'b0 || busy !== 1'b0 || addr !== 10'd0) begin
            errors++;
            $display("FAIL async_reset en=%b busy=%b addr=%h want 0/0/0", weight_read_en, busy, addr);
        end
        checks++;
        if (weight_last !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_flags last=%b done=%b want 0/0", weight_last, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (busy !== 1'b0 || weight_read_en !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d busy=%b en=%b want 0/0", i, busy, weight_read_en);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_pass();
        int b, d, oe, le, sg, dg;
        logic [9:0] pa;
        logic bd, ba;
        run_pass(-1, 0, -1, -1, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (b !== 784) begin errors++; $display("FAIL full_beats got %0d want 784", b); end
        checks++;
        if (oe !== 0) begin errors++; $display("FAIL full_order bad_beats=%0d want 0", oe); end
        checks++;
        if (le !== 0) begin errors++; $display("FAIL full_last bad_beats=%0d want 0", le); end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", d); end
        checks++;
        if (dg !== 1) begin errors++; $display("FAIL full_done_latency got %0d want 1", dg); end
        checks++;
        if (bd !== 1'b1 || ba !== 1'b0) begin
            errors++;
            $display("FAIL full_busy on_done=%b after=%b want 1/0", bd, ba);
        end
    endtask

    task automatic test_back_pressure();
        int b, d, oe, le, sg, dg;
        logic [9:0] pa;
        logic bd, ba;
        run_pass(391, 5, -1, -1, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (sg !== 5) begin errors++; $display("FAIL stall_frozen good_cycles=%0d want 5", sg); end
        checks++;
        if (pa !== 10'b10_00000_000) begin errors++; $display("FAIL stall_release addr=%h want %h", pa, 10'b10_00000_000); end
        checks++;
        if (b !== 784 || oe !== 0) begin
            errors++;
            $display("FAIL stall_pass beats=%0d order_err=%0d want 784/0", b, oe);
        end
        checks++;
        if (d !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", d); end
    endtask

    task automatic test_start_while_busy();
        int b, d, oe, le, sg, dg;
        logic [9:0] pa;
        logic bd, ba;
        run_pass(-1, 0, 100, -1, 1'b1, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (b !== 784 || oe !== 0) begin
            errors++;
            $display("FAIL busy_start_beats beats=%0d order_err=%0d want 784/0", b, oe);
        end
        checks++;
        if (d !== 1 || ba !== 1'b0) begin
            errors++;
            $display("FAIL done_start dones=%0d busy_after=%b want 1/0", d, ba);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL no_queued_start cyc=%0d busy=%b want 0", i, busy); end
            @(posedge clk); #1;
        end
        run_pass(-1, 0, -1, -1, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (b !== 784 || d !== 1) begin
            errors++;
            $display("FAIL second_pass beats=%0d dones=%0d want 784/1", b, d);
        end
    endtask

    task automatic test_reset_mid_pass();
        int b, d, oe, le, sg, dg, seen_done;
        logic [9:0] pa;
        logic bd, ba;
        run_pass(-1, 0, -1, 300, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (addr !== 10'b01_01110_110) begin errors++; $display("FAIL beat300_addr got %h want %h", addr, 10'b01_01110_110); end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || addr !== 10'd0 || weight_read_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b addr=%h en=%b want 0/0/0", busy, addr, weight_read_en);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done !== 0) begin errors++; $display("FAIL mid_reset_no_done got %0d want 0", seen_done); end
        run_pass(-1, 0, -1, -1, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (b !== 784 || oe !== 0 || d !== 1) begin
            errors++;
            $display("FAIL post_reset_pass beats=%0d order_err=%0d dones=%0d want 784/0/1", b, oe, d);
        end
    endtask

`ifdef WEIGHT_SEQ_ABORT_EN
    task automatic test_abort();
        int b, d, oe, le, sg, dg;
        logic [9:0] pa;
        logic bd, ba;
        run_pass(-1, 0, -1, 50, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        abort = 1'b1;
        start = 1'b1;
        #1;
        checks++;
        if (weight_read_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_cycle en=%b busy=%b want 0/1", weight_read_en, busy);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || addr !== 10'd0) begin
            errors++;
            $display("FAIL abort_idle busy=%b done=%b addr=%h want 0/0/0", busy, done, addr);
        end
        @(posedge clk); #1;
        run_pass(-1, 0, -1, -1, 1'b0, b, d, oe, le, sg, pa, dg, bd, ba);
        checks++;
        if (b !== 784 || oe !== 0 || d !== 1) begin
            errors++;
            $display("FAIL abort_rerun beats=%0d order_err=%0d dones=%0d want 784/0/1", b, oe, d);
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        conv_ready = 1'b0;
`ifdef WEIGHT_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        test_reset();
        test_full_pass();
        test_back_pressure();
        test_start_while_busy();
        test_reset_mid_pass();
`ifdef WEIGHT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_seq_ctrl.md
Name: weight_seq_ctrl

Overview:
Sequencer for the weight buffer read path of the CNN convolution engine. It walks the weight address space for every filter, column-fastest then row. It issues one weight_read_en per accepted beat, honours back-pressure from the conv engine, and flags the last beat of each filter and the end of the pass. It sits between the layer controller (start/done) and the weight buffer plus MAC array.

Parameters:
WEIGHT_SIZE_COL, 7, columns per filter (col address wraps at this value)
WEIGHT_SIZE_ROW, 28, rows per filter (row address wraps at this value)
WEIGHT_ADDR_COL, 3, width of the column address
WEIGHT_ADDR_ROW, 5, width of the row address
NUM_FILTER, 4, filters sequenced per pass
FILTER_ADDR, 2, width of the filter index

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a pass; honoured only in IDLE
conv_ready  input  1  conv engine can accept a weight beat this cycle
weight_read_en  output  1  weight buffer read strobe; one beat per high cycle
weight_addr_col  output  WEIGHT_ADDR_COL  column address of the current beat
weight_addr_row  output  WEIGHT_ADDR_ROW  row address of the current beat
filter_idx  output  FILTER_ADDR  filter index of the current beat
weight_last  output  1  high with the final beat (row ROW-1, col COL-1) of each filter
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at the end of a pass

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. reset high forces IDLE and all registered outputs to 0 immediately, with no clock needed.
- States: IDLE, READ, DONE. State and address/index counters are registered.
- IDLE: when start=1 on a clk edge, go to READ and clear col, row and filter to 0. Otherwise hold.
- READ:
  - weight_read_en = conv_ready (combinational from state and conv_ready).
  - A beat is accepted on an edge where weight_read_en=1.
  - conv_ready=0: weight_read_en=0 and all addresses hold. Stalls have no time limit.
- Counter advance on each accepted beat:
  - col increments.
  - When col==COL-1, col wraps to 0 and row increments.
  - When row==ROW-1 and col==COL-1, row wraps to 0 and filter increments.
  - When filter==NUM_FILTER-1 as well, go to DONE. Counters return to 0.
- weight_last = (state==READ) & (row==ROW-1) & (col==COL-1). It is asserted independent of conv_ready and held through stalls.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 only in IDLE.
- Latency: start edge to first possible beat is 1 cycle. With conv_ready tied high, a pass is COL*ROW*NUM_FILTER beat cycles (784 at defaults), plus 1 DONE cycle.
- start while busy is ignored; no queuing.
- start in the same cycle done is high is ignored. A new start is accepted from the following IDLE cycle.
- Counter widths must hold SIZE-1. Compare against SIZE-1 exactly; never rely on natural overflow. This keeps non-power-of-two sizes correct.
- Reset mid-pass aborts the pass: no done pulse, counters return to 0.

Optional Feature:
Macro WEIGHT_SEQ_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 on a clk edge in READ or DONE sends the FSM to IDLE and zeroes the counters.
  - done is not pulsed.
  - weight_read_en is forced 0 in any cycle abort=1.
  - abort in IDLE has no effect.
  - abort has priority over start and over beat acceptance.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- Reset then idle: assert reset async, mid-cycle -> all outputs 0 immediately. Release, no start -> busy=0 and weight_read_en=0 for 20 cycles.
- Full pass, conv_ready=1: pulse start -> exactly 784 weight_read_en cycles. Addresses step (0,0,0),(0,0,1)…(0,0,6),(0,1,0)…(3,27,6). weight_last high on beats 196, 392, 588 and 784. done high exactly 1 cycle after beat 784; busy falls the next cycle.
- Back-pressure: hold conv_ready=0 for 5 cycles at filter 1, row 27, col 6 -> weight_read_en=0 and addresses frozen for those 5 cycles, with weight_last held 1. On release, the beat completes and filter_idx becomes 2 with row=0, col=0.
- start during busy and on the done cycle: extra start at beat 100 and on the done cycle -> beat count stays 784. The second pass begins only after a start issued in IDLE.
- Reset mid-pass: reset at beat 300 -> busy=0 and counters 0 at once, no done. A new start gives a full 784-beat pass from (0,0,0).
- WEIGHT_SEQ_ABORT_EN build: abort at beat 50 together with start -> FSM in IDLE next cycle, no done, weight_read_en=0 during the abort cycle. A start 2 cycles later runs a full pass.
